// File: rtl/fp_div_pkg.sv
// Shared widths, constants and multiplier operand selects for the Goldschmidt divider.
package fp_div_pkg;

  localparam int unsigned W  = 27;          // Q1.26 datapath
  localparam int unsigned PW = 54;          // Q2.52 product

  localparam logic [W-1:0] ONE = 27'h4000000;

  // Multiplier X operand select (sel_mux4)
  typedef enum logic [1:0] {
    X_NM = 2'b00,
    X_DM = 2'b01,
    X_A  = 2'b10,
    X_B  = 2'b11
  } x_sel_e;

  // Multiplier Y operand select (sel_mux3)
  typedef enum logic [1:0] {
    Y_IA   = 2'b00,
    Y_C    = 2'b01,
    Y_DM   = 2'b10,
    Y_ZERO = 2'b11
  } y_sel_e;

  // round(1024 / (1 + (i + 0.5)/256)) == round(524288 / (513 + 2i)), integer-only
  function automatic logic [9:0] recip_entry(input int unsigned i);
    int unsigned d;
    d = 513 + 2 * i;
    return 10'((1048576 + d) / (2 * d));
  endfunction

endpackage

// File: rtl/fp_div_recip_rom.sv
// Initial reciprocal approximation table indexed by the top divisor fraction bits.
module fp_div_recip_rom
  import fp_div_pkg::*;
(
  input  logic [7:0]   idx,
  output logic [W-1:0] ia
);

  logic [9:0] entry_tbl [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign entry_tbl[i] = recip_entry(i);
  end

  assign ia = {1'b0, entry_tbl[idx], 16'b0};

endmodule

// File: rtl/fp_div.sv
// Goldschmidt mantissa divider: one shared 27x27 multiplier sequenced by an
// external controller, with remainder-based final rounding.
module fp_div
  import fp_div_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   inputNum,
  input  logic [31:0]   inputDenom,
  input  logic          en_a,
  input  logic          en_b,
  input  logic          en_rem,
  input  logic          rm,
  output logic [PW-1:0] out,
  output logic [W-1:0]  tb_rega,
  output logic [W-1:0]  tb_regb,
  output logic [W-1:0]  tb_regc,
  input  logic [1:0]    sel_mux3,
  input  logic [1:0]    sel_mux4,
  output logic [W-1:0]  rrem,
  output logic [W-1:0]  Q_sum,
  output logic [W-1:0]  QP_sum,
  output logic [W-1:0]  QM_sum,
  output logic [W-1:0]  Qmux_out,
  output logic [22:0]   final_mant
);

  logic [W-1:0]       nm, dm, ia;
  logic [W-1:0]       reg_a, reg_b, reg_c, rrem_q;
  logic [W-1:0]       mux_x, mux_y, prod_hi;
  logic [W-1:0]       ulp, half_ulp, mid, thr, neg_thr;
  logic               norm_hi, ulp_bit, overshoot, rnd_up;
  logic signed [54:0] rem;
  x_sel_e             x_sel;
  y_sel_e             y_sel;
  logic               unused_bits;

  assign nm    = {1'b1, inputNum[22:0], 3'b000};
  assign dm    = {1'b1, inputDenom[22:0], 3'b000};
  assign x_sel = x_sel_e'(sel_mux4);
  assign y_sel = y_sel_e'(sel_mux3);

  fp_div_recip_rom u_rom (
    .idx (inputDenom[22:15]),
    .ia  (ia)
  );

  // Quotient normalization: estimate at/above 1.0 keeps one fewer fraction bit.
  assign norm_hi  = (reg_a >= ONE);
  assign ulp      = norm_hi ? 27'd8 : 27'd4;
  assign half_ulp = norm_hi ? 27'd4 : 27'd2;
  assign Q_sum    = norm_hi ? {reg_a[26:3], 3'b000} : {reg_a[26:2], 2'b00};
  assign QP_sum   = Q_sum + ulp;
  assign QM_sum   = Q_sum - ulp;
  assign mid      = Q_sum + half_ulp;
  assign ulp_bit  = norm_hi ? Q_sum[3] : Q_sum[2];

  // X operand select; A is replaced by the rounding midpoint during the remainder step.
  always_comb begin
    mux_x = '0;
    case (x_sel)
      X_NM:    mux_x = nm;
      X_DM:    mux_x = dm;
      X_A:     mux_x = (y_sel == Y_DM) ? mid : reg_a;
      X_B:     mux_x = reg_b;
      default: mux_x = '0;
    endcase
  end

  // Y operand select.
  always_comb begin
    mux_y = '0;
    case (y_sel)
      Y_IA:    mux_y = ia;
      Y_C:     mux_y = reg_c;
      Y_DM:    mux_y = dm;
      Y_ZERO:  mux_y = '0;
      default: mux_y = '0;
    endcase
  end

  assign out     = PW'(mux_x) * PW'(mux_y);
  assign prod_hi = out[52:26];

  // N - M*D in Q2.52, signed; only the window around the ulp*D scale is kept.
  assign rem = $signed({2'b00, nm, 26'b0}) - $signed({1'b0, out});

  // Iteration registers and remainder capture; C tracks 2-B as B is loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_a  <= '0;
      reg_b  <= '0;
      reg_c  <= '0;
      rrem_q <= '0;
    end else begin
      if (en_a) reg_a <= prod_hi;
      if (en_b) begin
        reg_b <= prod_hi;
        reg_c <= ~prod_hi + 27'd1;
      end
      if (en_rem) rrem_q <= rem[31:5];
    end
  end

  assign tb_rega = reg_a;
  assign tb_regb = reg_b;
  assign tb_regc = reg_c;
  assign rrem    = rrem_q;

  // Half-ulp*D in rrem scaling; a remainder below its negative means Q_sum is one ulp high.
  assign thr       = norm_hi ? {3'b000, dm[26:3]} : {4'b0000, dm[26:4]};
  assign neg_thr   = '0 - thr;
  assign overshoot = $signed(rrem_q) < $signed(neg_thr);
  assign rnd_up    = rm && ((!rrem_q[W-1] && (rrem_q != '0)) || ((rrem_q == '0) && ulp_bit));

  // Final quotient selection: overshoot correction wins, then round-nearest-even.
  always_comb begin
    Qmux_out = Q_sum;
    if (overshoot)   Qmux_out = QM_sum;
    else if (rnd_up) Qmux_out = QP_sum;
  end

  assign final_mant = norm_hi ? Qmux_out[25:3] : Qmux_out[24:2];

  assign unused_bits = ^{inputNum[31:23], inputDenom[31:23], rem[54:32], rem[4:0]};

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: the driver acts as the sequencing controller and
// queues expectations; the monitor checks each completed division.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inputNum, inputDenom;
  logic        en_a, en_b, en_rem, rm;
  logic [53:0] out;
  logic [26:0] tb_rega, tb_regb, tb_regc;
  logic [1:0]  sel_mux3, sel_mux4;
  logic [26:0] rrem, Q_sum, QP_sum, QM_sum, Qmux_out;
  logic [22:0] final_mant;

  logic        strobe = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    string       name;
    logic [22:0] mant;
    bit          chk_b;
    bit          chk_rpos;
    bit          chk_exact;
    logic [26:0] a, rr, qs, qp, qm;
  } exp_t;

  exp_t sb[$];

  fp_div dut (
    .clk        (clk),
    .reset      (reset),
    .inputNum   (inputNum),
    .inputDenom (inputDenom),
    .en_a       (en_a),
    .en_b       (en_b),
    .en_rem     (en_rem),
    .rm         (rm),
    .out        (out),
    .tb_rega    (tb_rega),
    .tb_regb    (tb_regb),
    .tb_regc    (tb_regc),
    .sel_mux3   (sel_mux3),
    .sel_mux4   (sel_mux4),
    .rrem       (rrem),
    .Q_sum      (Q_sum),
    .QP_sum     (QP_sum),
    .QM_sum     (QM_sum),
    .Qmux_out   (Qmux_out),
    .final_mant (final_mant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [22:0] m);
    exp_t e;
    e.name = nm; e.mant = m;
    e.chk_b = 1'b0; e.chk_rpos = 1'b0; e.chk_exact = 1'b0;
    e.a = '0; e.rr = '0; e.qs = '0; e.qp = '0; e.qm = '0;
    return e;
  endfunction

  // Exact quotient of the significands, rounded to 24 significant bits.
  function automatic logic [22:0] ref_mant(input logic [22:0] fn, input logic [22:0] fd, input bit r);
    longint unsigned n, d, t, rr;
    int unsigned sh;
    n  = {40'd1, fn};
    d  = {40'd1, fd};
    sh = (n < d) ? 24 : 23;
    t  = (n << sh) / d;
    rr = (n << sh) - t * d;
    if (r && ((2 * rr > d) || ((2 * rr == d) && t[0]))) t++;
    return 23'(t);
  endfunction

  // Keep quotients sitting near the middle of the low sub-ulp range, away from
  // ulp boundaries the iteration's last-bit truncation error could cross.
  function automatic bit safe_vec(input logic [22:0] fn, input logic [22:0] fd);
    longint unsigned n, d, qu, r, pos;
    n   = {40'd1, fn};
    d   = {40'd1, fd};
    qu  = (n << 26) / d;
    r   = (n << 26) % d;
    pos = (n < d) ? (qu % 4) : (qu % 8);
    return (pos == 2) && (4 * r >= d) && (4 * r <= 3 * d);
  endfunction

  task automatic step(input logic [1:0] m4, input logic [1:0] m3,
                      input logic ea, input logic eb, input logic er);
    @(negedge clk);
    sel_mux4 = m4; sel_mux3 = m3; en_a = ea; en_b = eb; en_rem = er;
  endtask

  task automatic run_div(input logic [31:0] n, input logic [31:0] d, input logic r, input exp_t e);
    sb.push_back(e);
    @(negedge clk);
    inputNum = n; inputDenom = d; rm = r;
    sel_mux4 = 2'b00; sel_mux3 = 2'b00; en_a = 1'b1; en_b = 1'b0; en_rem = 1'b0;
    step(2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int unsigned k = 0; k < 5; k++) begin
      step(2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
      step(2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
    end
    step(2'b10, 2'b10, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0; en_rem = 1'b0; sel_mux3 = 2'b11;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  // Monitor: one completed division per strobe, checked against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (strobe) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_result: got %0h, expected no result", final_mant);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".mant"}, 64'(final_mant), 64'(e.mant));
          if (e.chk_b) begin
            n_tests++;
            if (tb_regb < 27'h3FFFFFF || tb_regb > 27'h4000001) begin
              n_fail++;
              $display("FAIL %s.regb: got %0h, expected 4000000+-1", e.name, tb_regb);
            end
          end
          if (e.chk_rpos) begin
            n_tests++;
            if (rrem[26] || rrem == '0) begin
              n_fail++;
              $display("FAIL %s.rrem_sign: got %0h, expected positive", e.name, rrem);
            end
          end
          if (e.chk_exact) begin
            chk({e.name, ".rega"},   64'(tb_rega), 64'(e.a));
            chk({e.name, ".rrem"},   64'(rrem),    64'(e.rr));
            chk({e.name, ".q_sum"},  64'(Q_sum),   64'(e.qs));
            chk({e.name, ".qp_sum"}, 64'(QP_sum),  64'(e.qp));
            chk({e.name, ".qm_sum"}, 64'(QM_sum),  64'(e.qm));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [22:0] fn, fd;
    int unsigned found;

    reset = 1'b1; inputNum = '0; inputDenom = '0; rm = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_rem = 1'b0; sel_mux3 = 2'b11; sel_mux4 = 2'b00;
    #1 reset = 1'b0;
    #1;
    chk("reset0.rega", 64'(tb_rega), 64'h0);
    @(negedge clk) reset = 1'b1;

    // Partial 1.0/1.0 sequence, then an asynchronous abort between clock edges.
    @(negedge clk);
    inputNum = 32'h3F800000; inputDenom = 32'h3F800000; rm = 1'b1;
    sel_mux4 = 2'b00; sel_mux3 = 2'b00; en_a = 1'b1;
    step(2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0;
    #1;
    chk("seed.rega", 64'(tb_rega), 64'h3FE0000);
    chk("seed.regb", 64'(tb_regb), 64'h3FE0000);
    chk("seed.regc", 64'(tb_regc), 64'h4020000);
    #1 reset = 1'b0;
    #1;
    chk("abort.rega", 64'(tb_rega), 64'h0);
    chk("abort.regb", 64'(tb_regb), 64'h0);
    chk("abort.regc", 64'(tb_regc), 64'h0);
    chk("abort.rrem", 64'(rrem),    64'h0);
    @(negedge clk) reset = 1'b1;

    e = mk("one_one", 23'h000000); e.chk_b = 1'b1;
    run_div(32'h3F800000, 32'h3F800000, 1'b1, e);

    e = mk("p15_one", 23'h400000); e.chk_exact = 1'b1;
    e.a = 27'h6000002; e.rr = 27'h7800000;
    e.qs = 27'h6000000; e.qp = 27'h6000008; e.qm = 27'h5FFFFF8;
    run_div(32'h3FC00000, 32'h3F800000, 1'b1, e);

    run_div(32'h3F800000, 32'h3FC00000, 1'b1, mk("one_p15_rne", 23'h2AAAAB));
    run_div(32'h3F800000, 32'h3FC00000, 1'b0, mk("one_p15_rz",  23'h2AAAAA));

    e = mk("p15_p15", 23'h000000); e.chk_rpos = 1'b1;
    run_div(32'h3FC00000, 32'h3FC00000, 1'b1, e);

    for (int unsigned v = 0; v < 8; v++) begin
      found = 0;
      for (int unsigned t = 0; t < 20000 && found == 0; t++) begin
        fn = 23'($urandom);
        fd = 23'($urandom);
        if (safe_vec(fn, fd)) found = 1;
      end
      if (found == 0) begin
        n_tests++; n_fail++;
        $display("FAIL vec_search: got none, expected a usable vector");
      end else begin
        run_div({9'h07F, fn}, {9'h07F, fd}, 1'b1, mk($sformatf("rne_%0d", v), ref_mant(fn, fd, 1'b1)));
        run_div({9'h07F, fn}, {9'h07F, fd}, 1'b0, mk($sformatf("rz_%0d", v),  ref_mant(fn, fd, 1'b0)));
      end
    end

    for (int unsigned i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
